master_addr_tx: RTL and testbench

//  Master-side address-phase transmitter for the serial bus. Requests the bus, then

---
 rtl/master_addr_tx_pkg.sv | 13 +
 rtl/master_addr_tx_if.sv | 29 ++
 rtl/master_addr_tx_counter.sv | 12 +
 rtl/master_addr_tx.sv | 78 +++++++
 tb/tb_master_addr_tx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/master_addr_tx_pkg.sv
// master_addr_tx_pkg: state encoding and slave-ID constants shared by the address transmitter
package master_addr_tx_pkg;
    localparam int SLAVE_ID_W = 2;
    typedef logic [SLAVE_ID_W-1:0] slave_id_t;
    localparam slave_id_t SID_NONE = 2'd0;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_SID   = 3'd2;
    localparam state_t ST_ADDR  = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_SPLIT = 3'd5;
endpackage

// File: rtl/master_addr_tx_if.sv
// master_addr_tx_if: request, arbiter, serial-bus and slave-response signals of one master
interface master_addr_tx_if
    import master_addr_tx_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic              M_START;
    slave_id_t         M_SLAVE;
    logic [ADDR_W-1:0] M_ADDR;
    logic              M_READY;
    logic              M_DONE;
    logic              M_ERR;
    logic              B_REQ;
    logic              B_GRANT;
    logic              B_UTIL;
    logic              A_ADD;
    logic              M_BUS_OUT;
    logic              S_ACK;
    logic              S_SPLIT;
    logic              S_SPL_RDY;
    modport master (
        input  M_START, M_SLAVE, M_ADDR, B_GRANT, S_ACK, S_SPLIT, S_SPL_RDY,
        output M_READY, M_DONE, M_ERR, B_REQ, B_UTIL, A_ADD, M_BUS_OUT
    );
    modport slave (
        output M_START, M_SLAVE, M_ADDR, B_GRANT, S_ACK, S_SPLIT, S_SPL_RDY,
        input  M_READY, M_DONE, M_ERR, B_REQ, B_UTIL, A_ADD, M_BUS_OUT
    );
endinterface

// File: rtl/master_addr_tx_counter.sv
// master_addr_tx_counter: clearable up-counter used as the serial bit index
module master_addr_tx_counter #(
    parameter int W = 4
) (
    input  logic         rst,
    input  logic         CLK,
    input  logic         incr,
    output logic [W-1:0] count
);
    always_ff @(posedge CLK)
        count <= rst ? '0 : incr ? count + 1'b1 : count;
endmodule

// File: rtl/master_addr_tx.sv
// master_addr_tx: serial-bus master address phase (slave ID then address, LSB-first) with split/regrant handling.
// Optional ack-wait timeout enabled by defining MASTER_ADDR_TX_TIMEOUT_EN.
module master_addr_tx
    import master_addr_tx_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TMO_CYC = 64
) (
    input logic              CLK,
    input logic              RST,
    master_addr_tx_if.master bus
);
    localparam int CW = $clog2(ADDR_W);
    state_t            st;
    state_t            nxt;
    slave_id_t         id;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     cnt;
    logic              tmo;
    logic              done;
    logic              err;
    logic              accept;
    assign accept = st == ST_IDLE && bus.M_START && bus.M_SLAVE != SID_NONE;
    // Counter restarts on every state change so each phase indexes from bit 0
    master_addr_tx_counter #(.W(CW)) u_cnt (
        .rst   (RST || nxt != st),
        .CLK   (CLK),
        .incr  (st == ST_SID || st == ST_ADDR),
        .count (cnt)
    );
`ifdef MASTER_ADDR_TX_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo = tmo_cnt == TW'(TMO_CYC - 1);
    always_ff @(posedge CLK)
        tmo_cnt <= (RST || st != ST_WAIT) ? '0 : tmo_cnt + 1'b1;
`else
    assign tmo = TMO_CYC < 0;  // constant 0: WAIT is untimed in this build
`endif
    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE:  nxt = accept ? ST_REQ : ST_IDLE;
            ST_REQ:   nxt = bus.B_GRANT ? ST_SID : ST_REQ;
            ST_SID:   nxt = !bus.B_GRANT ? ST_REQ : cnt == CW'(1) ? ST_ADDR : ST_SID;
            ST_ADDR:  nxt = !bus.B_GRANT ? ST_REQ : cnt == CW'(ADDR_W - 1) ? ST_WAIT : ST_ADDR;
            ST_WAIT:  nxt = bus.S_ACK ? ST_IDLE : !bus.B_GRANT ? ST_REQ :
                            bus.S_SPLIT ? ST_SPLIT : tmo ? ST_IDLE : ST_WAIT;
            ST_SPLIT: nxt = bus.S_SPL_RDY ? ST_REQ : ST_SPLIT;
            default:  nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            st   <= ST_IDLE;
            id   <= '0;
            addr <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            st   <= nxt;
            done <= st == ST_WAIT && bus.S_ACK;
            err  <= (st == ST_IDLE && bus.M_START && bus.M_SLAVE == SID_NONE) ||
                    (st == ST_WAIT && nxt == ST_IDLE && !bus.S_ACK);
            if (accept) begin
                id   <= bus.M_SLAVE;
                addr <= bus.M_ADDR;
            end
        end
    end
    assign bus.M_READY   = st == ST_IDLE;
    assign bus.M_DONE    = done;
    assign bus.M_ERR     = err;
    assign bus.B_REQ     = st == ST_REQ || st == ST_SID || st == ST_ADDR || st == ST_WAIT;
    assign bus.B_UTIL    = st == ST_SID || st == ST_ADDR || st == ST_WAIT;
    assign bus.A_ADD     = st == ST_SID;
    assign bus.M_BUS_OUT = st == ST_SID ? id[cnt[0]] : st == ST_ADDR ? addr[cnt] : 1'b0;
endmodule

// File: tb/tb_master_addr_tx.sv
// tb_master_addr_tx: randomized scoreboard bench; frames and pulses are predicted per transaction
module tb_master_addr_tx;
    localparam int AW  = 12;
    localparam int FL  = AW + 2;
    localparam int TMO = 64;
    typedef struct {
        int            kind;
        logic [1:0]    id;
        logic [AW-1:0] addr;
        int            len;
        int            start;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   pass = 0;
    int   total = 0;
    exp_t q[$];
    master_addr_tx_if #(.ADDR_W(AW)) bif ();
    master_addr_tx #(.ADDR_W(AW), .TMO_CYC(TMO)) dut (.CLK(clk), .RST(rst), .bus(bif));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (ok) pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask
    task automatic push(input int kind, input logic [1:0] id, input logic [AW-1:0] addr, input int len, input int start);
        exp_t e;
        e.kind = kind; e.id = id; e.addr = addr; e.len = len; e.start = start;
        q.push_back(e);
    endtask
    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask
    function automatic logic [6:0] outs();
        return {bif.M_READY, bif.M_DONE, bif.M_ERR, bif.B_REQ, bif.B_UTIL, bif.A_ADD, bif.M_BUS_OUT};
    endfunction
    // Monitor: a frame opens on A_ADD and closes when B_UTIL drops or FL bits are taken
    logic [FL-1:0] fbits;
    logic [FL-1:0] fa;
    int            fn = 0;
    int            fstart = 0;
    bit            in_frame = 1'b0;
    task automatic end_frame();
        exp_t          e;
        logic [FL-1:0] ex;
        logic [FL-1:0] m;
        if (q.size() == 0) begin
            chk(1'b0, "frame_unexpected", fn, 0);
            return;
        end
        e = q.pop_front();
        chk(e.kind == 0, "frame_kind", 0, e.kind);
        ex = {e.addr, e.id};
        m  = FL'((64'd1 << e.len) - 1);
        chk(fn == e.len, "frame_len", fn, e.len);
        chk(fstart == e.start, "frame_start", fstart, e.start);
        chk(fbits == (ex & m) && fa == (FL'(3) & m), "frame_bits", {fa, fbits}, {FL'(3) & m, ex & m});
    endtask
    task automatic pulse(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            chk(1'b0, "pulse_unexpected", kind, 0);
            return;
        end
        e = q.pop_front();
        chk(e.kind == kind, kind == 1 ? "done_pulse" : "err_pulse", kind, e.kind);
    endtask
    always @(negedge clk) begin
        if (in_frame && (!bif.B_UTIL || fn == FL)) begin
            end_frame();
            in_frame = 1'b0;
        end
        if (!in_frame && bif.B_UTIL && bif.A_ADD) begin
            in_frame = 1'b1;
            fn = 0;
            fstart = cyc;
            fbits = '0;
            fa = '0;
        end
        if (in_frame && fn < FL) begin
            fbits[fn] = bif.M_BUS_OUT;
            fa[fn] = bif.A_ADD;
            fn++;
        end
        if (bif.M_DONE && bif.M_ERR) chk(1'b0, "done_and_err", 3, 0);
        else if (bif.M_DONE) pulse(1);
        else if (bif.M_ERR) pulse(2);
    end
    // kind: 0 ack, 1 split then resend, 2 grant loss at bit k, 3 reset at bit k, 4 long wait
    task automatic send(input int kind, input logic [1:0] id, input logic [AW-1:0] addr,
                        input int r, input int k, input int d);
        int start;
        bif.M_START = 1'b1; bif.M_SLAVE = id; bif.M_ADDR = addr;
        if (id == 2'd0) begin
            push(2, id, addr, 0, 0);
            tick(1);
            bif.M_START = 1'b0;
            chk(bif.M_READY == 1'b1 && bif.B_REQ == 1'b0, "illegal_idle", {bif.M_READY, bif.B_REQ}, 2);
            tick(3);
            chk(bif.B_REQ == 1'b0, "illegal_no_req", bif.B_REQ, 0);
            return;
        end
        tick(1);
        bif.M_START = 1'($urandom); bif.M_SLAVE = 2'($urandom); bif.M_ADDR = AW'($urandom);
        chk(bif.B_REQ == 1'b1 && bif.M_READY == 1'b0, "req_asserted", {bif.B_REQ, bif.M_READY}, 2);
        tick(r);
        bif.B_GRANT = 1'b1;
        start = cyc + 1;
        if (kind == 2 || kind == 3) begin
            push(0, id, addr, k + 1, start);
            tick(1 + k);
            if (kind == 3) begin
                rst = 1'b1;
                tick(1);
                bif.M_START = 1'b0;
                chk(outs() == 7'b1000000, "reset_midframe", outs(), 7'b1000000);
                rst = 1'b0; bif.B_GRANT = 1'b0;
                tick(1);
                return;
            end
            bif.B_GRANT = 1'b0;
            tick(1);
            chk(bif.B_UTIL == 1'b0 && bif.B_REQ == 1'b1, "grant_loss", {bif.B_UTIL, bif.B_REQ}, 1);
            tick(r);
            bif.B_GRANT = 1'b1;
            start = cyc + 1;
        end
        push(0, id, addr, FL, start);
        tick(1 + FL);
        bif.M_START = 1'b0;
        if (kind == 1) begin
            tick(d);
            bif.S_SPLIT = 1'b1;
            tick(1);
            bif.S_SPLIT = 1'b0;
            chk(bif.B_UTIL == 1'b0 && bif.B_REQ == 1'b0, "split_release", {bif.B_UTIL, bif.B_REQ}, 0);
            tick(10);
            bif.S_SPL_RDY = 1'b1;
            tick(1);
            bif.S_SPL_RDY = 1'b0;
            chk(bif.B_REQ == 1'b1 && bif.B_UTIL == 1'b0, "split_rereq", {bif.B_REQ, bif.B_UTIL}, 2);
            start = cyc + 1;
            push(0, id, addr, FL, start);
            tick(1 + FL);
        end
        if (kind == 4) begin
`ifdef MASTER_ADDR_TX_TIMEOUT_EN
            push(2, id, addr, 0, 0);
            tick(TMO);
            chk(bif.M_READY == 1'b1, "timeout_idle", bif.M_READY, 1);
            bif.B_GRANT = 1'b0;
            tick(1);
            return;
`else
            tick(200);
            chk(bif.B_UTIL == 1'b1 && bif.B_REQ == 1'b1 && bif.M_READY == 1'b0, "wait_untimed",
                {bif.B_UTIL, bif.B_REQ, bif.M_READY}, 6);
`endif
        end
        tick(d);
        bif.S_ACK = 1'b1;
        push(1, id, addr, 0, 0);
        tick(1);
        bif.S_ACK = 1'b0; bif.B_GRANT = 1'b0;
        chk(bif.M_READY == 1'b1, "done_idle", bif.M_READY, 1);
        tick(1);
    endtask
    initial begin
        rst = 1'b1;
        bif.M_START = 1'b0; bif.M_SLAVE = 2'd0; bif.M_ADDR = '0; bif.B_GRANT = 1'b0;
        bif.S_ACK = 1'b0; bif.S_SPLIT = 1'b0; bif.S_SPL_RDY = 1'b0;
        tick(3);
        chk(outs() == 7'b1000000, "reset_state", outs(), 7'b1000000);
        rst = 1'b0;
        tick(1);
        send(0, 2'd2, 12'hA5C, 0, 0, 3);
        send(1, 2'd1, AW'($urandom), 1, 0, 1);
        send(2, 2'd3, AW'($urandom), 0, 7, 2);
        send(0, 2'd0, AW'($urandom), 0, 0, 0);
        send(3, 2'd2, AW'($urandom), 0, 9, 0);
        send(4, 2'd1, AW'($urandom), 2, 0, 1);
        repeat (40)
            send($urandom_range(0, 3), 2'($urandom_range(0, 3)), AW'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, FL - 1), $urandom_range(0, 3));
        tick(5);
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
